// File: rtl/bus_fabric16.sv
// CPU-to-peripheral bus fabric: table-driven region decode, per-region wait states,
// hold handshake, registered read data and sticky unmapped-access error capture.
module bus_fabric16 #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned N_REGIONS  = 5,
   parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
      {16'hF000, 16'h4000, 16'h3000, 16'h2000, 16'h0000},
   parameter logic [N_REGIONS*ADDR_WIDTH-1:0] REGION_MASK =
      {16'hF000, 16'hFFFF, 16'hF000, 16'hF000, 16'hF000},
   parameter logic [N_REGIONS*4-1:0] REGION_WAIT = {4'd1, 4'd0, 4'd0, 4'd0, 4'd0},
   parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA = '0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           cpu_valid,
   input  logic [ADDR_WIDTH-1:0]          cpu_addr,
   input  logic                           cpu_we,
   input  logic [DATA_WIDTH-1:0]          cpu_wdata,
   output logic [DATA_WIDTH-1:0]          cpu_rdata,
   output logic                           cpu_ready,
   output logic                           cpu_hold,
   output logic [ADDR_WIDTH-1:0]          bus_addr,
   output logic [DATA_WIDTH-1:0]          bus_wdata,
   output logic [N_REGIONS-1:0]           slv_sel,
   output logic [N_REGIONS-1:0]           slv_we,
   input  logic [N_REGIONS*DATA_WIDTH-1:0] slv_rdata,
   output logic                           bus_err,
   output logic [ADDR_WIDTH-1:0]          err_addr,
   input  logic                           err_clear
);

   localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [IDX_W-1:0]      region_q, region_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

   logic                  hit;
   logic [IDX_W-1:0]      hit_idx;
   logic [3:0]            hit_wait;
   logic [DATA_WIDTH-1:0] rdata_sel;

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      hit_wait = 4'd0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if ((cpu_addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
             REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit      = 1'b1;
            hit_idx  = IDX_W'(i);
            hit_wait = REGION_WAIT[i*4 +: 4];
         end
      end
   end

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (region_q == IDX_W'(i)) rdata_sel = slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      region_d   = region_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (err_clear) err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cpu_valid) begin
               addr_d   = cpu_addr;
               we_d     = cpu_we;
               wdata_d  = cpu_wdata;
               region_d = hit_idx;
               cnt_d    = hit_wait;
               if (hit) begin
                  state_d = ST_ACCESS;
               end else begin
                  // A fresh unmapped access outranks a simultaneous clear.
                  state_d    = ST_RESP;
                  err_d      = 1'b1;
                  err_addr_d = cpu_addr;
                  if (!cpu_we) rdata_d = DEFAULT_DATA;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (!we_q) rdata_d = rdata_sel;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         region_q   <= '0;
         cnt_q      <= 4'd0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         region_q   <= region_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   // Write strobe is masked by reset so an aborted final cycle never commits.
   always_comb begin
      slv_sel = '0;
      slv_we  = '0;
      for (int i = 0; i < N_REGIONS; i++) begin
         if (state_q == ST_ACCESS && region_q == IDX_W'(i)) begin
            slv_sel[i] = 1'b1;
            slv_we[i]  = we_q && (cnt_q == 4'd0) && reset_n;
         end
      end
   end

   assign cpu_ready = (state_q == ST_RESP);
   assign cpu_hold  = (state_q == ST_ACCESS);
   assign cpu_rdata = rdata_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_err   = err_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_fabric16.sv
// Directed bench for bus_fabric16 with the default five-region map and static slave data.
module tb_bus_fabric16;

   logic        clk;
   logic        reset_n;
   logic        cpu_valid;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_hold;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic [4:0]  slv_sel;
   logic [4:0]  slv_we;
   logic [79:0] slv_rdata;
   logic        bus_err;
   logic [15:0] err_addr;
   logic        err_clear;

   int checks;
   int failures;

   bus_fabric16 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_valid (cpu_valid),
      .cpu_addr  (cpu_addr),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_hold  (cpu_hold),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .slv_sel   (slv_sel),
      .slv_we    (slv_we),
      .slv_rdata (slv_rdata),
      .bus_err   (bus_err),
      .err_addr  (err_addr),
      .err_clear (err_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [15:0] addr, input logic we, input logic [15:0] wdata);
      cpu_valid = 1'b1;
      cpu_addr  = addr;
      cpu_we    = we;
      cpu_wdata = wdata;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      checks += 5;
      if (cpu_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", cpu_rdata); end
      if (bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin
         failures++; $display("FAIL reset_bus got=%h/%h exp=0000/0000", bus_addr, bus_wdata);
      end
      if (cpu_ready !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++; $display("FAIL reset_hs got=%b%b exp=00", cpu_ready, cpu_hold);
      end
      if (slv_sel !== 5'b0 || slv_we !== 5'b0) begin
         failures++; $display("FAIL reset_sel got=%b/%b exp=0/0", slv_sel, slv_we);
      end
      if (bus_err !== 1'b0 || err_addr !== 16'h0) begin
         failures++; $display("FAIL reset_err got=%b/%h exp=0/0000", bus_err, err_addr);
      end
   endtask

   task automatic test_read_ram();
      request(16'h0123, 1'b0, 16'h0);
      step();
      cpu_valid = 1'b0;
      checks += 3;
      if (slv_sel !== 5'b00001) begin failures++; $display("FAIL ram_sel got=%b exp=00001", slv_sel); end
      if (cpu_hold !== 1'b1 || cpu_ready !== 1'b0) begin
         failures++; $display("FAIL ram_c1_hs hold=%b ready=%b exp=1/0", cpu_hold, cpu_ready);
      end
      if (bus_addr !== 16'h0123) begin failures++; $display("FAIL ram_addr got=%h exp=0123", bus_addr); end
      step();
      checks += 2;
      if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hBEEF) begin
         failures++; $display("FAIL ram_resp ready=%b rdata=%h exp=1/beef", cpu_ready, cpu_rdata);
      end
      if (cpu_hold !== 1'b0 || slv_sel !== 5'b0) begin
         failures++; $display("FAIL ram_c2 hold=%b sel=%b exp=0/00000", cpu_hold, slv_sel);
      end
      step();
      checks++;
      if (cpu_ready !== 1'b0) begin failures++; $display("FAIL ram_c3_ready got=%b exp=0", cpu_ready); end
   endtask

   task automatic test_write();
      request(16'h2010, 1'b1, 16'h00A5);
      step();
      cpu_valid = 1'b0;
      checks += 2;
      if (slv_we !== 5'b00010 || slv_sel !== 5'b00010) begin
         failures++; $display("FAIL wr_strobe we=%b sel=%b exp=00010/00010", slv_we, slv_sel);
      end
      if (bus_wdata !== 16'h00A5 || bus_addr !== 16'h2010) begin
         failures++; $display("FAIL wr_bus got=%h/%h exp=00a5/2010", bus_wdata, bus_addr);
      end
      step();
      checks += 2;
      if (slv_we !== 5'b0 || cpu_ready !== 1'b1) begin
         failures++; $display("FAIL wr_resp we=%b ready=%b exp=00000/1", slv_we, cpu_ready);
      end
      if (cpu_rdata !== 16'hBEEF) begin failures++; $display("FAIL wr_rdata got=%h exp=beef", cpu_rdata); end
      step();
   endtask

   task automatic test_rom_wait();
      request(16'hF004, 1'b0, 16'h0);
      step();
      cpu_valid = 1'b0;
      checks++;
      if (cpu_hold !== 1'b1 || slv_sel !== 5'b10000 || cpu_ready !== 1'b0) begin
         failures++; $display("FAIL rom_c1 hold=%b sel=%b ready=%b exp=1/10000/0", cpu_hold, slv_sel, cpu_ready);
      end
      step();
      checks++;
      if (cpu_hold !== 1'b1 || slv_sel !== 5'b10000 || cpu_ready !== 1'b0) begin
         failures++; $display("FAIL rom_c2 hold=%b sel=%b ready=%b exp=1/10000/0", cpu_hold, slv_sel, cpu_ready);
      end
      step();
      checks++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hCAFE || cpu_hold !== 1'b0) begin
         failures++; $display("FAIL rom_resp ready=%b rdata=%h hold=%b exp=1/cafe/0", cpu_ready, cpu_rdata, cpu_hold);
      end
      step();
   endtask

   task automatic test_unmapped();
      request(16'h5000, 1'b0, 16'h0);
      step();
      cpu_valid = 1'b0;
      checks += 2;
      if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h0000 || slv_sel !== 5'b0) begin
         failures++; $display("FAIL unm_resp ready=%b rdata=%h sel=%b exp=1/0000/00000", cpu_ready, cpu_rdata, slv_sel);
      end
      if (bus_err !== 1'b1 || err_addr !== 16'h5000) begin
         failures++; $display("FAIL unm_err got=%b/%h exp=1/5000", bus_err, err_addr);
      end
      step();
      request(16'h6000, 1'b0, 16'h0);
      err_clear = 1'b1;
      step();
      cpu_valid = 1'b0;
      err_clear = 1'b0;
      checks++;
      if (bus_err !== 1'b1 || err_addr !== 16'h6000 || cpu_ready !== 1'b1) begin
         failures++; $display("FAIL unm_clear_prio got=%b/%h/%b exp=1/6000/1", bus_err, err_addr, cpu_ready);
      end
      step();
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      checks++;
      if (bus_err !== 1'b0 || err_addr !== 16'h6000) begin
         failures++; $display("FAIL unm_clear got=%b/%h exp=0/6000", bus_err, err_addr);
      end
   endtask

   task automatic test_exact_mask();
      request(16'h4000, 1'b0, 16'h0);
      step();
      cpu_valid = 1'b0;
      checks++;
      if (slv_sel !== 5'b01000) begin failures++; $display("FAIL r3_sel got=%b exp=01000", slv_sel); end
      step();
      checks++;
      if (cpu_rdata !== 16'h4444 || bus_err !== 1'b0) begin
         failures++; $display("FAIL r3_data got=%h/%b exp=4444/0", cpu_rdata, bus_err);
      end
      step();
      request(16'h4001, 1'b0, 16'h0);
      step();
      cpu_valid = 1'b0;
      checks++;
      if (bus_err !== 1'b1 || err_addr !== 16'h4001 || slv_sel !== 5'b0 || cpu_ready !== 1'b1) begin
         failures++; $display("FAIL r3_unm got=%b/%h/%b/%b exp=1/4001/00000/1", bus_err, err_addr, slv_sel, cpu_ready);
      end
      step();
   endtask

   task automatic test_back_to_back();
      request(16'h0000, 1'b0, 16'h0);
      step();
      step();
      checks++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== 16'hBEEF || cpu_hold !== 1'b0) begin
         failures++; $display("FAIL b2b_first ready=%b rdata=%h hold=%b exp=1/beef/0", cpu_ready, cpu_rdata, cpu_hold);
      end
      cpu_addr = 16'h2000;
      step();
      checks++;
      if (cpu_ready !== 1'b0 || cpu_hold !== 1'b0) begin
         failures++; $display("FAIL b2b_idle ready=%b hold=%b exp=0/0", cpu_ready, cpu_hold);
      end
      step();
      cpu_valid = 1'b0;
      checks++;
      if (slv_sel !== 5'b00010 || cpu_hold !== 1'b1) begin
         failures++; $display("FAIL b2b_sel got=%b/%b exp=00010/1", slv_sel, cpu_hold);
      end
      step();
      checks++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h2222) begin
         failures++; $display("FAIL b2b_second ready=%b rdata=%h exp=1/2222", cpu_ready, cpu_rdata);
      end
      step();
   endtask

   task automatic test_reset_mid_access();
      request(16'hF000, 1'b1, 16'h1234);
      step();
      cpu_valid = 1'b0;
      step();
      reset_n = 1'b0;
      #1;
      checks++;
      if (slv_we !== 5'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=00000", slv_we); end
      step();
      reset_n = 1'b1;
      checks += 2;
      if (cpu_ready !== 1'b0 || cpu_hold !== 1'b0 || slv_sel !== 5'b0 || slv_we !== 5'b0) begin
         failures++; $display("FAIL rst_mid_hs got=%b%b/%b/%b exp=00/0/0", cpu_ready, cpu_hold, slv_sel, slv_we);
      end
      if (cpu_rdata !== 16'h0 || bus_addr !== 16'h0 || bus_wdata !== 16'h0 || bus_err !== 1'b0 || err_addr !== 16'h0) begin
         failures++; $display("FAIL rst_mid_regs got=%h/%h/%h/%b/%h exp=0/0/0/0/0", cpu_rdata, bus_addr, bus_wdata, bus_err, err_addr);
      end
      step();
      checks++;
      if (cpu_ready !== 1'b0 || slv_we !== 5'b0) begin
         failures++; $display("FAIL rst_mid_after ready=%b we=%b exp=0/00000", cpu_ready, slv_we);
      end
      request(16'h3000, 1'b0, 16'h0);
      step();
      cpu_valid = 1'b0;
      checks++;
      if (slv_sel !== 5'b00100) begin failures++; $display("FAIL rst_new_sel got=%b exp=00100", slv_sel); end
      step();
      checks++;
      if (cpu_ready !== 1'b1 || cpu_rdata !== 16'h3333) begin
         failures++; $display("FAIL rst_new_resp ready=%b rdata=%h exp=1/3333", cpu_ready, cpu_rdata);
      end
      step();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      cpu_valid = 1'b0;
      cpu_addr  = 16'h0;
      cpu_we    = 1'b0;
      cpu_wdata = 16'h0;
      err_clear = 1'b0;
      slv_rdata = {16'hCAFE, 16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
      #1;
      test_reset();
      test_read_ram();
      test_write();
      test_rom_wait();
      test_unmapped();
      test_exact_mask();
      test_back_to_back();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
